// File: rtl/grant_decoder_if.sv
// Request-index stream in, one-hot grant and status out, between the encoder and the agents.
interface grant_decoder_if #(
  parameter int CODE_W = 3
);
  localparam int N_OUT = 2 ** CODE_W;

  logic [CODE_W-1:0] code_in;
  logic              code_valid;
  logic              code_ready;
  logic [N_OUT-1:0]  ack;
  logic              clr_err;
  logic [N_OUT-1:0]  grant;
  logic              busy;
  logic              grant_done;
  logic              timeout_err;
  logic [CODE_W-1:0] err_code;

  modport master (
    output code_in, code_valid, ack, clr_err,
    input  code_ready, grant, busy, grant_done, timeout_err, err_code
  );

  modport slave (
    input  code_in, code_valid, ack, clr_err,
    output code_ready, grant, busy, grant_done, timeout_err, err_code
  );
endinterface

// File: rtl/grant_decoder.sv
// Buffers encoded indices in a 2-deep FIFO and holds a one-hot grant until ack or timeout.
// Grant appears one edge after the index reaches the FIFO; code_ready deasserts while both slots are full.
module grant_decoder #(
  parameter int CODE_W  = 3,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  grant_decoder_if.slave   bus
);
  localparam int N_OUT = 2 ** CODE_W;
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);
  localparam logic [N_OUT-1:0] ONE = {{(N_OUT-1){1'b0}}, 1'b1};

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  logic [CODE_W-1:0] r_mem [2];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_count;

  state_t            r_state;
  logic [CODE_W-1:0] r_code;
  logic [7:0]        r_timer;
  logic [N_OUT-1:0]  r_grant;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic [CODE_W-1:0] r_err_code;

  logic              w_ready;
  logic              w_push;
  logic              w_pop;
  logic [CODE_W-1:0] w_head;
  logic              w_ack_hit;

  // A full FIFO refuses pushes even when the head is popped on the same edge.
  assign w_ready   = (r_count < 2'd2);
  assign w_push    = bus.code_valid && w_ready;
  assign w_pop     = (r_state == S_IDLE) && (r_count != 2'd0);
  assign w_head    = r_mem[r_rd_ptr];
  assign w_ack_hit = bus.ack[r_code];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= bus.code_in;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_code     <= '0;
      r_timer    <= 8'd0;
      r_grant    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= '0;
    end else begin
      r_done <= 1'b0;
      // Cleared first so that a timeout on the same edge overrides it.
      if (bus.clr_err) begin
        r_err <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_code  <= w_head;
            r_grant <= ONE << w_head;
            r_timer <= 8'd0;
            r_busy  <= 1'b1;
            r_state <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (w_ack_hit) begin
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else if (r_timer == TIMER_LAST) begin
            r_grant    <= '0;
            r_busy     <= 1'b0;
            r_err      <= 1'b1;
            r_err_code <= r_code;
            r_state    <= S_IDLE;
          end else begin
            r_timer <= r_timer + 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.code_ready  = w_ready;
  assign bus.grant       = r_grant;
  assign bus.busy        = r_busy;
  assign bus.grant_done  = r_done;
  assign bus.timeout_err = r_err;
  assign bus.err_code    = r_err_code;
endmodule

// File: tb/tb_grant_decoder.sv
// Random and directed stimulus for grant_decoder, compared each cycle against a queue-based reference model.
module tb_grant_decoder;
  localparam int CODE_W  = 3;
  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  grant_decoder_if #(.CODE_W(CODE_W)) bus ();

  grant_decoder #(.CODE_W(CODE_W), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: pending indices in a queue, held grant as code plus cycles-high count.
  int q[$];
  bit m_busy;
  int m_code;
  int m_held;
  bit m_done;
  bit m_err;
  int m_errcode;
  bit m_pushed;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_busy = 0; m_code = 0; m_held = 0;
    m_done = 0; m_err = 0; m_errcode = 0; m_pushed = 0;
  endtask

  task automatic model_edge(input bit vld, input int code, input logic [7:0] ack, input bit clr);
    bit rdy;
    bit push;
    rdy  = (q.size() < 2);
    push = vld && rdy;
    m_done = 0;
    if (clr) m_err = 0;
    if (m_busy) begin
      if (ack[m_code]) begin
        m_busy = 0;
        m_done = 1;
      end else if (m_held == TIMEOUT) begin
        m_busy    = 0;
        m_err     = 1;
        m_errcode = m_code;
      end else begin
        m_held++;
      end
    end else if (q.size() > 0) begin
      m_code = q.pop_front();
      m_busy = 1;
      m_held = 1;
    end
    if (push) q.push_back(code);
    m_pushed = push;
  endtask

  task automatic compare_all();
    logic [7:0] exp_grant;
    exp_grant = m_busy ? (8'd1 << m_code) : 8'd0;
    check("grant", bus.grant, exp_grant);
    check("busy", bus.busy, m_busy);
    check("grant_done", bus.grant_done, m_done);
    check("timeout_err", bus.timeout_err, m_err);
    check("err_code", bus.err_code, m_errcode);
    check("code_ready", bus.code_ready, q.size() < 2);
  endtask

  // Called at a negedge: drive inputs, take the edge, compare at the next negedge.
  task automatic step(input bit vld, input int code, input logic [7:0] ack, input bit clr);
    bus.code_valid = vld;
    bus.code_in    = code[CODE_W-1:0];
    bus.ack        = ack;
    bus.clr_err    = clr;
    @(posedge clk);
    model_edge(vld, code, ack, clr);
    @(negedge clk);
    compare_all();
  endtask

  task automatic wait_grant();
    for (int i = 0; i < 20 && !m_busy; i++) step(0, 0, 8'h00, 0);
  endtask

  task automatic serve(input int code);
    logic [7:0] exp_grant;
    exp_grant = 8'd1 << code;
    wait_grant();
    check("serve_grant", bus.grant, exp_grant);
    step(0, 0, exp_grant, 0);
    check("serve_done", bus.grant_done, 1);
  endtask

  initial begin
    int hi_cnt;
    int vld;
    int code;
    logic [7:0] ack;
    bit clr;

    model_reset();
    bus.code_valid = 0; bus.code_in = '0; bus.ack = '0; bus.clr_err = 0;
    repeat (2) @(negedge clk);
    check("rst_grant", bus.grant, 0);
    check("rst_ready", bus.code_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_err", bus.timeout_err, 0);
    check("rst_err_code", bus.err_code, 0);
    rst = 1'b1;

    // Code 5: grant one edge after entering the FIFO, released by ack at E3.
    step(1, 5, 8'h00, 0);
    step(0, 0, 8'h00, 0);
    check("e1_grant", bus.grant, 8'h20);
    step(0, 0, 8'h00, 0);
    step(0, 0, 8'h20, 0);
    check("e3_grant", bus.grant, 8'h00);
    check("e3_done", bus.grant_done, 1);
    step(0, 0, 8'h00, 0);
    check("done_pulse", bus.grant_done, 0);

    // Code 2 without ack: held exactly TIMEOUT cycles.
    step(1, 2, 8'h00, 0);
    step(0, 0, 8'h00, 0);
    hi_cnt = (bus.grant == 8'h04) ? 1 : 0;
    for (int i = 0; i < 40 && m_busy; i++) begin
      step(0, 0, 8'h00, 0);
      if (bus.grant == 8'h04) hi_cnt++;
    end
    check("to_cycles", hi_cnt, TIMEOUT);
    check("to_err", bus.timeout_err, 1);
    check("to_err_code", bus.err_code, 2);
    step(0, 0, 8'h00, 1);
    check("clr_err", bus.timeout_err, 0);
    check("clr_keeps_code", bus.err_code, 2);

    // Fill the FIFO behind a held grant on code 1.
    step(1, 1, 8'h00, 0);
    wait_grant();
    step(1, 3, 8'h00, 0);
    step(1, 6, 8'h00, 0);
    check("full_ready", bus.code_ready, 0);
    step(1, 0, 8'h00, 0);
    check("full_hold", bus.code_ready, 0);
    step(1, 0, 8'h02, 0);
    check("ack1_done", bus.grant_done, 1);
    for (int i = 0; i < 10 && !m_pushed; i++) step(1, 0, 8'h00, 0);
    check("code0_accepted", m_pushed, 1);
    step(0, 0, 8'h00, 0);
    serve(3);
    serve(6);
    serve(0);

    // Wrong-agent ack held, correct ack lands on the final timeout cycle.
    step(1, 4, 8'h00, 0);
    wait_grant();
    for (int i = 0; i < 40 && m_busy && m_held < TIMEOUT; i++) step(0, 0, 8'h01, 0);
    check("late_grant", bus.grant, 8'h10);
    step(0, 0, 8'h11, 0);
    check("late_done", bus.grant_done, 1);
    check("late_no_err", bus.timeout_err, 0);

    // Timeout on the same edge as clr_err: set wins.
    step(1, 3, 8'h00, 0);
    wait_grant();
    for (int i = 0; i < 40 && m_busy && m_held < TIMEOUT; i++) step(0, 0, 8'h00, 0);
    step(0, 0, 8'h00, 1);
    check("set_wins", bus.timeout_err, 1);
    check("set_wins_code", bus.err_code, 3);

    // Asynchronous reset with a grant held and two entries queued.
    step(1, 7, 8'h00, 0);
    wait_grant();
    step(1, 1, 8'h00, 0);
    step(1, 2, 8'h00, 0);
    check("pre_rst_ready", bus.code_ready, 0);
    #2 rst = 1'b0;
    #1;
    check("arst_grant", bus.grant, 0);
    check("arst_ready", bus.code_ready, 1);
    check("arst_busy", bus.busy, 0);
    check("arst_err", bus.timeout_err, 0);
    model_reset();
    bus.code_valid = 0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 0);
    check("post_rst_idle", bus.grant, 0);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      vld  = $urandom_range(0, 1);
      code = $urandom_range(0, 7);
      case ($urandom_range(0, 7))
        0:       ack = m_busy ? (8'd1 << m_code) : 8'h00;
        1, 2:    ack = 8'($urandom);
        default: ack = 8'h00;
      endcase
      clr = ($urandom_range(0, 15) == 0);
      step(vld[0], code, ack, clr);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
